// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - state codes, field widths and geometry shared by the flappy game blocks
package flappy_pkg;

  // HUD-visible state codes; codes 5..7 are unused and recover to IDLE
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_RESPAWN = 3'd3,
    ST_OVER    = 3'd4
  } state_e;

  localparam int SCORE_W = 8;
  localparam int LIVES_W = 2;

  // Screen, ball and pillar geometry used by the game logic and renderer
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int BALL_SIZE  = 16;
  localparam int PILLAR_W   = 64;
  localparam int PILLAR_GAP = 160;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchroniser with rising-edge pulse for board inputs
module btn_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two stages to settle metastability, a third flop remembers the last level for edge detect
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// rtl/flappy_game_ctrl.sv - game step divider, start/pause/respawn/over sequencer, lives and high score
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int TICK_DIV      = 833333,
  parameter int LIVES         = 3,
  parameter int RESPAWN_TICKS = 90,
  parameter int OVER_TICKS    = 180
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_btn,
  input  logic               pause_sw,
  input  logic               crash,
  input  logic [SCORE_W-1:0] score,
  output logic               game_en,
  output logic               game_rst,
  output logic [2:0]         state,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] hi_score,
  output logic               new_record
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST     = DIV_W'(TICK_DIV - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(LIVES);
  localparam logic [7:0]         RESPAWN_LAST = 8'(RESPAWN_TICKS);
  localparam logic [7:0]         OVER_LAST    = 8'(OVER_TICKS);

  logic start_pulse;
  logic pause_s;

  btn_sync_edge u_start_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (start_btn),
    .q      (),
    .rise   (start_pulse)
  );

  btn_sync_edge u_pause_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pause_sw),
    .q      (pause_s),
    .rise   ()
  );

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  // Free-running step divider; only resetn restarts it so step phase is independent of game state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  state_e             state_q;
  logic               game_en_q;
  logic               game_rst_q;
  logic [LIVES_W-1:0] lives_q;
  logic [SCORE_W-1:0] hi_q;
  logic               new_record_q;
  logic [7:0]         wait_q;
  logic [7:0]         wait_inc;

  assign wait_inc = wait_q + 8'd1;

  // Game flow sequencer: all outputs registered, lives and high score updated alongside the state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      game_en_q    <= 1'b0;
      game_rst_q   <= 1'b1;
      lives_q      <= LIVES_INIT;
      hi_q         <= '0;
      new_record_q <= 1'b0;
      wait_q       <= '0;
    end else begin
      game_en_q <= tick & (state_q == ST_PLAY) & ~pause_s;
      case (state_q)
        ST_IDLE: begin
          game_rst_q <= 1'b1;
          lives_q    <= LIVES_INIT;
          if (start_pulse) begin
            state_q      <= ST_PLAY;
            game_rst_q   <= 1'b0;
            new_record_q <= 1'b0;
          end
        end
        ST_PLAY: begin
          game_rst_q <= 1'b0;
          if (score > hi_q) begin
            hi_q         <= score;
            new_record_q <= 1'b1;
          end
          // A crash outranks a pause arriving in the same cycle
          if (crash) begin
            wait_q <= '0;
            if (lives_q == LIVES_W'(1)) begin
              lives_q <= '0;
              state_q <= ST_OVER;
            end else begin
              lives_q <= lives_q - LIVES_W'(1);
              state_q <= ST_RESPAWN;
            end
          end else if (pause_s) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (!pause_s) begin
            state_q <= ST_PLAY;
          end
        end
        ST_RESPAWN: begin
          if (tick) begin
            wait_q <= wait_inc;
            if (wait_inc == RESPAWN_LAST) begin
              state_q <= ST_PLAY;
            end
          end
        end
        ST_OVER: begin
          // Return to IDLE only; a fresh press is needed to play again
          if (start_pulse) begin
            state_q    <= ST_IDLE;
            game_rst_q <= 1'b1;
            lives_q    <= LIVES_INIT;
          end else if (tick) begin
            wait_q <= wait_inc;
            if (wait_inc == OVER_LAST) begin
              state_q    <= ST_IDLE;
              game_rst_q <= 1'b1;
              lives_q    <= LIVES_INIT;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          game_rst_q <= 1'b1;
          lives_q    <= LIVES_INIT;
        end
      endcase
    end
  end

  assign game_en    = game_en_q;
  assign game_rst   = game_rst_q;
  assign state      = state_q;
  assign lives      = lives_q;
  assign hi_score   = hi_q;
  assign new_record = new_record_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb/tb_flappy_game_ctrl.sv - randomized and directed bench for flappy_game_ctrl against a behavioural model
module tb_flappy_game_ctrl;

  localparam int TICK_DIV      = 4;
  localparam int LIVES         = 3;
  localparam int RESPAWN_TICKS = 2;
  localparam int OVER_TICKS    = 3;

  logic       clk       = 1'b0;
  logic       resetn    = 1'b1;
  logic       start_btn = 1'b0;
  logic       pause_sw  = 1'b0;
  logic       crash     = 1'b0;
  logic [7:0] score     = 8'd0;
  logic       game_en;
  logic       game_rst;
  logic [2:0] state;
  logic [1:0] lives;
  logic [7:0] hi_score;
  logic       new_record;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flappy_game_ctrl #(
    .TICK_DIV      (TICK_DIV),
    .LIVES         (LIVES),
    .RESPAWN_TICKS (RESPAWN_TICKS),
    .OVER_TICKS    (OVER_TICKS)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_btn  (start_btn),
    .pause_sw   (pause_sw),
    .crash      (crash),
    .score      (score),
    .game_en    (game_en),
    .game_rst   (game_rst),
    .state      (state),
    .lives      (lives),
    .hi_score   (hi_score),
    .new_record (new_record)
  );

  // Behavioural model: clock-edge count drives the step phase, input histories give the synchronised views
  typedef struct packed {
    int st;
    int lv;
    int wt;
    int hi;
    int n;
    bit nr;
    bit en;
    bit rst;
    bit sb1, sb2, sb3;
    bit pb1, pb2;
  } model_t;

  model_t mdl;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.lv  = LIVES;
    r.rst = 1'b1;
    return r;
  endfunction

  function automatic model_t model_next(model_t m, bit btn, bit psw, bit crs, logic [7:0] sc);
    model_t r;
    bit sp, ps, tk;
    r  = m;
    sp = m.sb2 && !m.sb3;
    ps = m.pb2;
    tk = (m.n % TICK_DIV) == (TICK_DIV - 1);
    r.en = tk && (m.st == 1) && !ps;
    case (m.st)
      0: if (sp) begin r.st = 1; r.rst = 1'b0; r.nr = 1'b0; end
      1: begin
        if (int'(sc) > m.hi) begin r.hi = int'(sc); r.nr = 1'b1; end
        if (crs) begin
          r.wt = 0;
          r.lv = m.lv - 1;
          r.st = (m.lv == 1) ? 4 : 3;
        end else if (ps) begin
          r.st = 2;
        end
      end
      2: if (!ps) r.st = 1;
      3: if (tk) begin r.wt = m.wt + 1; if (r.wt == RESPAWN_TICKS) r.st = 1; end
      4: begin
        if (sp) r.st = 0;
        else if (tk) begin r.wt = m.wt + 1; if (r.wt == OVER_TICKS) r.st = 0; end
      end
      default: r.st = 0;
    endcase
    if (r.st == 0) begin r.lv = LIVES; r.rst = 1'b1; end
    r.sb3 = m.sb2; r.sb2 = m.sb1; r.sb1 = btn;
    r.pb2 = m.pb1; r.pb1 = psw;
    r.n   = m.n + 1;
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) mdl <= model_reset();
    else         mdl <= model_next(mdl, start_btn, pause_sw, crash, score);
  end

  wire  [15:0] dut_v = {state, lives, hi_score, new_record, game_en, game_rst};
  logic [15:0] mdl_v;
  always_comb mdl_v = {mdl.st[2:0], mdl.lv[1:0], mdl.hi[7:0], mdl.nr, mdl.en, mdl.rst};

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget && !ok) begin
      cyc();
      cycles++;
      ok = (state == s);
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    cyc();
    start_btn = 1'b0;
    cyc();
  endtask

  task automatic pulse_crash();
    crash = 1'b1;
    cyc();
    crash = 1'b0;
  endtask

  // Drive a running game through all its lives and back into a fresh PLAY
  task automatic end_game(output bit ok);
    int  c;
    bit  w;
    ok = 1'b1;
    pause_sw = 1'b0;
    for (int i = 0; i < LIVES; i++) begin
      pulse_crash();
      if (state != 3'd4) begin
        wait_state(3'd1, 40, c, w);
        ok &= w;
      end
    end
    press_start();
    wait_state(3'd0, 40, c, w);
    ok &= w;
    press_start();
    wait_state(3'd1, 40, c, w);
    ok &= w;
  endtask

  task automatic test_reset();
    logic [15:0] exp_v;
    exp_v = {3'd0, 2'd3, 8'd0, 1'b0, 1'b0, 1'b1};
    #2 resetn = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if (dut_v !== exp_v) begin n_bad++; $display("FAIL reset_state got=%h exp=%h", dut_v, exp_v); end
    n_cmp++;
    if (dut_v !== mdl_v) begin n_bad++; $display("FAIL reset_model got=%h exp=%h", dut_v, mdl_v); end
    resetn = 1'b1;
  endtask

  task automatic test_start();
    int   en_cnt, b2b;
    logic prev_en;
    logic [2:0] exp_s;
    cyc();
    start_btn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      start_btn = 1'b0;
      exp_s = (k == 3) ? 3'd1 : 3'd0;
      n_cmp++;
      if (state !== exp_s) begin n_bad++; $display("FAIL start_latency k=%0d got=%0d exp=%0d", k, state, exp_s); end
    end
    n_cmp++;
    if (game_rst !== 1'b0) begin n_bad++; $display("FAIL start_game_rst got=%b exp=0", game_rst); end
    en_cnt = 0; b2b = 0; prev_en = 1'b0;
    repeat (4 * TICK_DIV) begin
      cyc();
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL start_model t=%0t got=%h exp=%h", $time, dut_v, mdl_v); end
      if (game_en) en_cnt++;
      if (game_en && prev_en) b2b++;
      prev_en = game_en;
    end
    n_cmp++;
    if (en_cnt != 4 || b2b != 0) begin
      n_bad++; $display("FAIL start_game_en pulses=%0d back2back=%0d exp=4/0", en_cnt, b2b);
    end
  endtask

  task automatic test_respawn();
    int en_cnt, cnt;
    pulse_crash();
    n_cmp++;
    if (lives !== 2'd2 || state !== 3'd3) begin
      n_bad++; $display("FAIL respawn_enter lives=%0d state=%0d exp=2/3", lives, state);
    end
    en_cnt = 0; cnt = 0;
    while (state == 3'd3 && cnt < 40) begin
      cyc();
      cnt++;
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL respawn_model t=%0t got=%h exp=%h", $time, dut_v, mdl_v); end
      if (game_en && state == 3'd3) en_cnt++;
    end
    n_cmp++;
    if (state !== 3'd1 || en_cnt != 0 || cnt < (RESPAWN_TICKS - 1) * TICK_DIV + 1 || cnt > RESPAWN_TICKS * TICK_DIV) begin
      n_bad++; $display("FAIL respawn_exit state=%0d en=%0d cycles=%0d exp=1/0/5..8", state, en_cnt, cnt);
    end
  endtask

  task automatic test_game_over();
    int c, cnt;
    bit ok;
    pulse_crash();
    n_cmp++;
    if (lives !== 2'd1) begin n_bad++; $display("FAIL over_lives1 got=%0d exp=1", lives); end
    wait_state(3'd1, 40, c, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL over_respawn_timeout state=%0d exp=1", state); end
    pulse_crash();
    n_cmp++;
    if (lives !== 2'd0 || state !== 3'd4) begin
      n_bad++; $display("FAIL over_enter lives=%0d state=%0d exp=0/4", lives, state);
    end
    cnt = 0;
    while (state == 3'd4 && cnt < 40) begin
      cyc();
      cnt++;
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL over_model t=%0t got=%h exp=%h", $time, dut_v, mdl_v); end
    end
    n_cmp++;
    if (state !== 3'd0 || game_rst !== 1'b1 || cnt < (OVER_TICKS - 1) * TICK_DIV + 1 || cnt > OVER_TICKS * TICK_DIV) begin
      n_bad++; $display("FAIL over_exit state=%0d rst=%b cycles=%0d exp=0/1/9..12", state, game_rst, cnt);
    end
    press_start();
    wait_state(3'd1, 20, c, ok);
    n_cmp++;
    if (!ok || lives !== 2'd3) begin n_bad++; $display("FAIL over_restart ok=%b lives=%0d exp=1/3", ok, lives); end
  endtask

  task automatic test_pause();
    int en_cnt;
    pause_sw = 1'b1;
    repeat (3) cyc();
    n_cmp++;
    if (state !== 3'd2) begin n_bad++; $display("FAIL pause_enter got=%0d exp=2", state); end
    en_cnt = 0;
    repeat (3 * TICK_DIV) begin
      cyc();
      if (game_en) en_cnt++;
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL pause_model t=%0t got=%h exp=%h", $time, dut_v, mdl_v); end
    end
    n_cmp++;
    if (en_cnt != 0) begin n_bad++; $display("FAIL pause_game_en got=%0d exp=0", en_cnt); end
    pulse_crash();
    cyc();
    n_cmp++;
    if (lives !== 2'd3 || state !== 3'd2) begin
      n_bad++; $display("FAIL pause_crash lives=%0d state=%0d exp=3/2", lives, state);
    end
    pause_sw = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if (state !== 3'd1) begin n_bad++; $display("FAIL pause_exit got=%0d exp=1", state); end
  endtask

  task automatic test_hiscore();
    bit ok;
    score = 8'd0; repeat (2) cyc();
    score = 8'd7; repeat (2) cyc();
    score = 8'd5; repeat (2) cyc();
    n_cmp++;
    if (hi_score !== 8'd7 || new_record !== 1'b1) begin
      n_bad++; $display("FAIL hi_first hi=%0d rec=%b exp=7/1", hi_score, new_record);
    end
    n_cmp++;
    if (dut_v !== mdl_v) begin n_bad++; $display("FAIL hi_model1 got=%h exp=%h", dut_v, mdl_v); end
    end_game(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL hi_game2_timeout state=%0d exp=1", state); end
    score = 8'd7; repeat (4) cyc();
    n_cmp++;
    if (hi_score !== 8'd7 || new_record !== 1'b0) begin
      n_bad++; $display("FAIL hi_equal hi=%0d rec=%b exp=7/0", hi_score, new_record);
    end
    end_game(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL hi_game3_timeout state=%0d exp=1", state); end
    score = 8'd9; repeat (4) cyc();
    n_cmp++;
    if (hi_score !== 8'd9 || new_record !== 1'b1) begin
      n_bad++; $display("FAIL hi_beat hi=%0d rec=%b exp=9/1", hi_score, new_record);
    end
  endtask

  task automatic test_crash_pause();
    int c;
    bit ok1, ok2;
    pulse_crash();
    wait_state(3'd1, 40, c, ok1);
    pulse_crash();
    wait_state(3'd1, 40, c, ok2);
    n_cmp++;
    if (!ok1 || !ok2 || lives !== 2'd1) begin
      n_bad++; $display("FAIL cp_setup ok=%b%b lives=%0d exp=11/1", ok1, ok2, lives);
    end
    pause_sw = 1'b1;
    cyc();
    cyc();
    crash = 1'b1;
    cyc();
    crash = 1'b0;
    n_cmp++;
    if (state !== 3'd4 || lives !== 2'd0) begin
      n_bad++; $display("FAIL cp_crash_wins state=%0d lives=%0d exp=4/0", state, lives);
    end
    pause_sw = 1'b0;
    wait_state(3'd0, 40, c, ok1);
    n_cmp++;
    if (!ok1) begin n_bad++; $display("FAIL cp_over_timeout state=%0d exp=0", state); end
  endtask

  task automatic test_random();
    repeat (1500) begin
      cyc();
      n_cmp++;
      if (dut_v !== mdl_v) begin n_bad++; $display("FAIL rand_model t=%0t got=%h exp=%h", $time, dut_v, mdl_v); end
      crash = ($urandom % 16) == 0;
      if (($urandom % 8) == 0)  start_btn = ~start_btn;
      if (($urandom % 40) == 0) pause_sw  = ~pause_sw;
      if (($urandom % 4) == 0)  score     = 8'($urandom);
    end
    crash = 1'b0; start_btn = 1'b0; pause_sw = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c;
    bit ok;
    score  = 8'd0;
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    press_start();
    wait_state(3'd1, 20, c, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mid_start_timeout state=%0d exp=1", state); end
    score = 8'd33;
    repeat (3) cyc();
    n_cmp++;
    if (hi_score !== 8'd33 || new_record !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre hi=%0d rec=%b exp=33/1", hi_score, new_record);
    end
    #1 resetn = 1'b0;
    #1;
    n_cmp++;
    if (game_rst !== 1'b1 || hi_score !== 8'd0 || state !== 3'd0 || new_record !== 1'b0 || lives !== 2'd3) begin
      n_bad++; $display("FAIL mid_async rst=%b hi=%0d state=%0d rec=%b lives=%0d exp=1/0/0/0/3",
                        game_rst, hi_score, state, new_record, lives);
    end
    n_cmp++;
    if (dut_v !== mdl_v) begin n_bad++; $display("FAIL mid_model got=%h exp=%h", dut_v, mdl_v); end
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_respawn();
    test_game_over();
    test_pause();
    test_hiscore();
    test_crash_pause();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
